// File: rtl/stack_calc_pkg.sv
// Shared types for the stack calculator: opcodes, error codes, FSM states and op-legality helpers.
// Combinational helpers only; STACK_CALC_DIV_EN decides whether DIV/MOD are legal opcodes.
// No flow control of its own.
package stack_calc_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [3:0] {
        OP_PUSH = 4'd0,
        OP_POP  = 4'd1,
        OP_INC  = 4'd2,
        OP_DEC  = 4'd3,
        OP_ADD  = 4'd4,
        OP_MUL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_DIV  = 4'd7,
        OP_MOD  = 4'd8,
        OP_DUP  = 4'd9,
        OP_SWAP = 4'd10,
        OP_CLR  = 4'd11
    } op_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE      = 3'd0,
        ERR_ILLEGAL   = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_OVERFLOW  = 3'd3,
        ERR_DIV_ZERO  = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    function automatic logic op_legal(op_e op);
`ifdef STACK_CALC_DIV_EN
        return op <= OP_CLR;
`else
        return (op <= OP_CLR) && (op != OP_DIV) && (op != OP_MOD);
`endif
    endfunction

    // Entries that must already be on the stack for the op to proceed.
    function automatic logic [1:0] min_operands(op_e op);
        case (op)
            OP_POP, OP_INC, OP_DEC, OP_DUP:                   return 2'd1;
            OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_MOD, OP_SWAP:  return 2'd2;
            default:                                          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_calc_if.sv
// Opcode request / status bundle between the panel controller (master) and the calculator (slave).
// Wires only, no latency; apply is honoured only while ready is high.
interface stack_calc_if
    import stack_calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 5
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [W-1:0]     in;
    logic [3:0]       op;
    logic             apply;
    logic             err_clr;
    logic             ready;
    logic [W-1:0]     head;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             valid;
    logic [ERR_W-1:0] err_code;

    modport master (
        output in, op, apply, err_clr,
        input  ready, head, depth, empty, full, valid, err_code
    );

    modport slave (
        input  in, op, apply, err_clr,
        output ready, head, depth, empty, full, valid, err_code
    );

endinterface

// File: rtl/stack_calc_div.sv
// W-bit unsigned restoring divider, one quotient bit per cycle.
// Latency: operands latched on start, done_o high during the cycle after W iteration edges.
// No backpressure: start must only be pulsed while idle; busy_o covers the whole run.
module stack_calc_div #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [W:0]    trial;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        // quo_q doubles as the dividend shift register, feeding its MSB into the remainder
        trial  = {rem_q, quo_q[W-1]};
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(W);
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d = W'(trial - {1'b0, dvs_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/stack_calc_p.sv
// Stack calculator with error FSM; STACK_CALC_DIV_EN adds a multi-cycle DIV/MOD via stack_calc_div.
// Latency: single-cycle ops visible the cycle after acceptance; DIV/MOD write back W+1 edges later.
// Backpressure: ready drops during DIV and in ERR (until err_clr); apply is ignored while not ready.
module stack_calc_p
    import stack_calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    stack_calc_if.slave  bus
);
    localparam int            DW   = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [W-1:0]  stk_q [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    state_e        state_q, state_d;
    err_e          err_q, err_d;

    op_e           op;
    err_e          chk;
    logic          acc;
    logic [DW-1:0] top_idx, sec_idx;
    logic [W-1:0]  opa, opb;
    logic          wa_en, wb_en;
    logic [DW-1:0] wa_idx, wb_idx;
    logic [W-1:0]  wa_dat, wb_dat;
    logic          div_busy, div_done;

    // Clamped indices keep reads in range when the stack is shallow.
    assign top_idx = (depth_q == '0)  ? '0 : depth_q - ONE;
    assign sec_idx = (depth_q < TWO)  ? '0 : depth_q - TWO;
    assign opb     = stk_q[top_idx];
    assign opa     = stk_q[sec_idx];
    assign op      = op_e'(bus.op);
    assign acc     = bus.apply && bus.ready;

    always_comb begin
        chk = ERR_NONE;
        if (!op_legal(op))
            chk = ERR_ILLEGAL;
        else if (depth_q < DW'(min_operands(op)))
            chk = ERR_UNDERFLOW;
        else if ((op == OP_PUSH || op == OP_DUP) && depth_q == FULL)
            chk = ERR_OVERFLOW;
        else if ((op == OP_DIV || op == OP_MOD) && opb == '0)
            chk = ERR_DIV_ZERO;
    end

`ifdef STACK_CALC_DIV_EN
    logic         is_mod_q;
    logic [W-1:0] div_quo, div_rem;
    logic         div_start;

    assign div_start = acc && (chk == ERR_NONE) && (op == OP_DIV || op == OP_MOD);

    stack_calc_div #(.W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (opa),
        .divisor_i  (opb),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst)            is_mod_q <= 1'b0;
        else if (div_start) is_mod_q <= (op == OP_MOD);
    end
`else
    assign div_busy = 1'b0;
    assign div_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (acc) begin
                if (chk != ERR_NONE) begin
                    state_d = ST_ERR;
                    err_d   = chk;
                end else if (op == OP_DIV || op == OP_MOD) begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV:  if (div_done) state_d = ST_IDLE;
            ST_ERR:  if (bus.err_clr) begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready    = (state_q == ST_IDLE) && !div_busy;
        bus.valid    = (state_q != ST_ERR);
        bus.err_code = err_q;
        bus.head     = (depth_q == '0) ? '0 : opb;
        bus.depth    = depth_q;
        bus.empty    = (depth_q == '0);
        bus.full     = (depth_q == FULL);
    end

    // Stack write-back: at most two entries change per edge (SWAP uses both ports).
    always_comb begin
        depth_d = depth_q;
        wa_en   = 1'b0;
        wa_idx  = top_idx;
        wa_dat  = opb;
        wb_en   = 1'b0;
        wb_idx  = sec_idx;
        wb_dat  = opa;
        if (acc && chk == ERR_NONE) begin
            case (op)
                OP_PUSH: begin wa_en = 1'b1; wa_idx = depth_q; wa_dat = bus.in; depth_d = depth_q + ONE; end
                OP_POP:  depth_d = depth_q - ONE;
                OP_INC:  begin wa_en = 1'b1; wa_dat = opb + W'(1); end
                OP_DEC:  begin wa_en = 1'b1; wa_dat = opb - W'(1); end
                OP_ADD:  begin wa_en = 1'b1; wa_idx = sec_idx; wa_dat = opa + opb; depth_d = depth_q - ONE; end
                OP_MUL:  begin wa_en = 1'b1; wa_idx = sec_idx; wa_dat = opa * opb; depth_d = depth_q - ONE; end
                OP_SUB:  begin wa_en = 1'b1; wa_idx = sec_idx; wa_dat = opa - opb; depth_d = depth_q - ONE; end
                OP_DUP:  begin wa_en = 1'b1; wa_idx = depth_q; wa_dat = opb; depth_d = depth_q + ONE; end
                OP_SWAP: begin wa_en = 1'b1; wa_dat = opa; wb_en = 1'b1; wb_dat = opb; end
                OP_CLR:  depth_d = '0;
                default: ;
            endcase
        end
`ifdef STACK_CALC_DIV_EN
        if (state_q == ST_DIV && div_done) begin
            wa_en   = 1'b1;
            wa_idx  = sec_idx;
            wa_dat  = is_mod_q ? div_rem : div_quo;
            depth_d = depth_q - ONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wa_en) stk_q[wa_idx] <= wa_dat;
        if (wb_en) stk_q[wb_idx] <= wb_dat;
    end

endmodule

// File: tb/tb_stack_calc_p.sv
// Randomised and directed checks of stack_calc_p against a queue-based behavioural model.
module tb_stack_calc_p;
    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int MASK  = (1 << W) - 1;
`ifdef STACK_CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    stack_calc_if #(.W(W), .DEPTH(DEPTH)) bus ();

    stack_calc_p #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mq[$];
    int merr    = 0;
    int mcnt    = 0;
    int mres    = 0;
    bit started = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int n, a, b, o, code, need;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            merr = 0;
            mcnt = 0;
            return;
        end
        if (merr != 0) begin
            if (bus.err_clr) merr = 0;
            return;
        end
        if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 0) begin
                void'(mq.pop_back());
                void'(mq.pop_back());
                mq.push_back(mres);
            end
            return;
        end
        if (!bus.apply) return;
        o = int'(bus.op);
        n = mq.size();
        b = (n >= 1) ? mq[n-1] : 0;
        a = (n >= 2) ? mq[n-2] : 0;
        need = (o == 1 || o == 2 || o == 3 || o == 9) ? 1 :
               ((o >= 4 && o <= 8) || o == 10) ? 2 : 0;
        code = 0;
        if (o > 11 || (!DIV_EN && (o == 7 || o == 8))) code = 1;
        else if (n < need)                             code = 2;
        else if ((o == 0 || o == 9) && n == DEPTH)     code = 3;
        else if ((o == 7 || o == 8) && b == 0)         code = 4;
        if (code != 0) begin
            merr = code;
            return;
        end
        case (o)
            0:  mq.push_back(int'(bus.in));
            1:  void'(mq.pop_back());
            2:  mq[n-1] = (b + 1) & MASK;
            3:  mq[n-1] = (b - 1) & MASK;
            4, 5, 6: begin
                void'(mq.pop_back());
                void'(mq.pop_back());
                mq.push_back(o == 4 ? (a + b) & MASK : o == 5 ? (a * b) & MASK : (a - b) & MASK);
            end
            7, 8: begin
                mcnt = W + 1;
                mres = (o == 7) ? a / b : a % b;
            end
            9:  mq.push_back(b);
            10: begin mq[n-1] = a; mq[n-2] = b; end
            11: mq.delete();
            default: ;
        endcase
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            int n;
            n = mq.size();
            check("ready",    int'(bus.ready),    (merr == 0 && mcnt == 0) ? 1 : 0);
            check("valid",    int'(bus.valid),    (merr == 0) ? 1 : 0);
            check("err_code", int'(bus.err_code), merr);
            check("depth",    int'(bus.depth),    n);
            check("head",     int'(bus.head),     (n == 0) ? 0 : mq[n-1]);
            check("empty",    int'(bus.empty),    (n == 0) ? 1 : 0);
            check("full",     int'(bus.full),     (n == DEPTH) ? 1 : 0);
        end
    end

    task automatic cyc(input logic ap, input logic [3:0] o, input logic [W-1:0] v, input logic ec);
        bus.apply   = ap;
        bus.op      = o;
        bus.in      = v;
        bus.err_clr = ec;
        @(posedge clk);
        #1;
        bus.apply   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] v);
        cyc(1'b1, o, v, 1'b0);
    endtask

    task automatic clear_err();
        cyc(1'b0, 4'd0, '0, 1'b1);
    endtask

    initial begin
        bus.apply   = 1'b0;
        bus.op      = 4'd0;
        bus.in      = '0;
        bus.err_clr = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", int'(bus.ready), 1);
        check("rst_valid", int'(bus.valid), 1);
        check("rst_err",   int'(bus.err_code), 0);
        check("rst_head",  int'(bus.head), 0);
        check("rst_depth", int'(bus.depth), 0);
        check("rst_empty", int'(bus.empty), 1);

        do_op(4'd0, 8'd7); do_op(4'd0, 8'd3); do_op(4'd4, 8'd0);
        check("add_head", int'(bus.head), 10);
        check("add_depth", int'(bus.depth), 1);
        check("add_err", int'(bus.err_code), 0);
        do_op(4'd0, 8'd200); do_op(4'd0, 8'd2); do_op(4'd5, 8'd0);
        check("mul_head", int'(bus.head), 144);

        do_op(4'd11, 8'd0);
        for (int i = 1; i <= 5; i++) do_op(4'd0, 8'(i));
        check("full_flag", int'(bus.full), 1);
        do_op(4'd0, 8'd6);
        check("ovf_err", int'(bus.err_code), 3);
        check("ovf_valid", int'(bus.valid), 0);
        check("ovf_ready", int'(bus.ready), 0);
        check("ovf_depth", int'(bus.depth), 5);
        check("ovf_head", int'(bus.head), 5);
        clear_err();
        check("clr_valid", int'(bus.valid), 1);
        check("clr_ready", int'(bus.ready), 1);
        check("clr_head", int'(bus.head), 5);

        do_op(4'd11, 8'd0);
        do_op(4'd1, 8'd0);
        check("pop_empty_err", int'(bus.err_code), 2);
        clear_err();
        do_op(4'd0, 8'd9); do_op(4'd10, 8'd0);
        check("swap_udf_err", int'(bus.err_code), 2);
        check("swap_udf_depth", int'(bus.depth), 1);
        clear_err();
        do_op(4'd11, 8'd0);
        check("clr_depth", int'(bus.depth), 0);
        check("clr_empty", int'(bus.empty), 1);

        do_op(4'd0, 8'd1); do_op(4'd0, 8'd2); do_op(4'd10, 8'd0);
        check("swap_head", int'(bus.head), 1);
        do_op(4'd9, 8'd0);
        check("dup_depth", int'(bus.depth), 3);
        check("dup_head", int'(bus.head), 1);
        do_op(4'd0, 8'd0); do_op(4'd3, 8'd0);
        check("dec_wrap", int'(bus.head), 255);
        do_op(4'd13, 8'd0);
        check("illegal_err", int'(bus.err_code), 1);
        clear_err();

`ifdef STACK_CALC_DIV_EN
        do_op(4'd11, 8'd0);
        do_op(4'd0, 8'd17); do_op(4'd0, 8'd5); do_op(4'd7, 8'd0);
        for (int i = 0; i < 9; i++) begin
            check("div_busy_ready", int'(bus.ready), 0);
            cyc(1'b0, 4'd0, '0, 1'b0);
        end
        check("div_done_ready", int'(bus.ready), 1);
        check("div_head", int'(bus.head), 3);
        check("div_depth", int'(bus.depth), 1);

        do_op(4'd11, 8'd0);
        do_op(4'd0, 8'd17); do_op(4'd0, 8'd5); do_op(4'd8, 8'd0);
        for (int k = 0; k < 20 && bus.ready !== 1'b1; k++) cyc(1'b0, 4'd0, '0, 1'b0);
        check("mod_ready", int'(bus.ready), 1);
        check("mod_head", int'(bus.head), 2);

        do_op(4'd11, 8'd0);
        do_op(4'd0, 8'd4); do_op(4'd0, 8'd0); do_op(4'd7, 8'd0);
        check("divz_err", int'(bus.err_code), 4);
        check("divz_depth", int'(bus.depth), 2);
        check("divz_head", int'(bus.head), 0);
        clear_err();

        do_op(4'd0, 8'd9); do_op(4'd7, 8'd0);
        cyc(1'b0, 4'd0, '0, 1'b0);
        cyc(1'b0, 4'd0, '0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 4'd0, '0, 1'b0);
        rst = 1'b0;
        check("rst_div_depth", int'(bus.depth), 0);
        check("rst_div_ready", int'(bus.ready), 1);
`else
        do_op(4'd0, 8'd8); do_op(4'd7, 8'd0);
        check("nodiv_err", int'(bus.err_code), 1);
        clear_err();
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] o;
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)       o = 4'($urandom_range(12, 15));
            else if (r < 35) o = 4'd0;
            else             o = 4'($urandom_range(0, 11));
            rst = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 3) != 0, o, W'($urandom), $urandom_range(0, 2) == 0);
            rst = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
